// File: rtl/stream_check.sv
// stream_check: AXI-stream sink that checks an incrementing 32-bit data
// pattern and frame framing (tlast position), with optional pseudo-random
// backpressure and saturating frame/error statistics.
module stream_check #(
    parameter int          FRAME_W   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               enable,
    input  logic               throttle,
    input  logic               clear,
    input  logic [FRAME_W-1:0] frame_size,
    input  logic [31:0]        tdata,
    input  logic [3:0]         tkeep,
    input  logic               tlast,
    input  logic               tvalid,
    output logic               tready,
    output logic [31:0]        frame_count,
    output logic [31:0]        err_count,
    output logic [31:0]        first_err,
    output logic               err_sticky,
    output logic               err_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_lfsr;
    logic [31:0]        r_exp;
    logic [FRAME_W-1:0] r_idx;
    logic [FRAME_W-1:0] r_fsize;
    logic [31:0]        r_frame_cnt;
    logic [31:0]        r_err_cnt;
    logic [31:0]        r_first_err;
    logic               r_sticky;
    logic               r_pulse;

    logic               w_stall;
    logic               w_tready;
    logic               w_accept;
    logic [FRAME_W-1:0] w_fs;
    logic               w_err_data;
    logic               w_err_keep;
    logic               w_err_early;
    logic               w_err_miss;
    logic               w_err;
    logic [FRAME_W-1:0] w_idx_nxt;

    assign w_stall  = throttle & r_lfsr[0];
    assign w_accept = tvalid & w_tready;

    // tready depends only on registered state and the LFSR, never on tvalid
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            S_IDLE:  w_tready = 1'b0;
            S_RUN:   w_tready = ~w_stall;
            S_DRAIN: w_tready = 1'b1;
            default: w_tready = 1'b0;
        endcase
    end

    // Per-beat error detection and next beat index
    always_comb begin
        // frame_size is live at the first beat of a frame, latched afterwards
        w_fs        = (r_idx == '0) ? frame_size : r_fsize;
        w_err_data  = (tdata != r_exp);
        w_err_keep  = (tkeep != 4'hF);
        w_err_early = tlast & (r_idx != w_fs);
        w_err_miss  = ~tlast & (r_idx == w_fs);
        w_err       = w_accept & (w_err_data | w_err_keep | w_err_early | w_err_miss);
        w_idx_nxt   = r_idx;
        if (clear) begin
            w_idx_nxt = '0;
        end else if (w_accept) begin
            // a missing last still closes the frame at frame_size
            if (tlast || (r_idx == w_fs)) begin
                w_idx_nxt = '0;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // judged on the index after this cycle's beat so a beat taken
                // on the same edge is not stranded mid-frame
                if (!enable) begin
                    w_state_nxt = (w_idx_nxt != '0) ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_accept && tlast && !clear) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Throttle LFSR: Fibonacci, taps 16,14,13,11, steps only while running
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == S_RUN) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Expected data, beat index, latched frame size and statistics
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_exp       <= '0;
            r_idx       <= '0;
            r_fsize     <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_sticky    <= 1'b0;
            r_pulse     <= 1'b0;
        end else if (clear) begin
            r_exp       <= '0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_sticky    <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_pulse <= w_err;
            r_idx   <= w_idx_nxt;
            if (w_accept) begin
                // on a mismatch, resync to the received data
                r_exp <= w_err_data ? (tdata + 32'd1) : (r_exp + 32'd1);
                if (r_idx == '0) begin
                    r_fsize <= frame_size;
                end
                if (tlast && (r_frame_cnt != '1)) begin
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                end
                if (w_err) begin
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + 32'd1;
                    end
                    if (!r_sticky) begin
                        r_first_err <= tdata;
                    end
                    r_sticky <= 1'b1;
                end
            end
        end
    end

    assign tready      = w_tready;
    assign frame_count = r_frame_cnt;
    assign err_count   = r_err_cnt;
    assign first_err   = r_first_err;
    assign err_sticky  = r_sticky;
    assign err_pulse   = r_pulse;

endmodule
